// File: rtl/vga_console_pkg.sv
// Shared console geometry, control codes and writer state encoding.
// SCROLL/CLEAR_ROW states exist only when VGA_TEXT_WRITER_SCROLL_EN is defined.
package vga_console_pkg;

    localparam int NUM_ROWS_DEF = 3;
    localparam int NUM_COLS_DEF = 10;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [6:0] CH_SPACE = 7'h20;

`ifdef VGA_TEXT_WRITER_SCROLL_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR_ALL,
        ST_SCROLL,
        ST_CLEAR_ROW
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR_ALL
    } state_e;
`endif

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    function automatic logic [5:0] cell_index(input logic [1:0] row, input logic [3:0] col,
                                              input int ncols);
        return 6'((int'(row) * ncols) + int'(col));
    endfunction

endpackage

// File: rtl/vga_text_writer.sv
// Character-stream console writer: cursor tracking, control codes, clear and scroll sequencing.
// Optional scroll-on-last-row behaviour is enabled by defining VGA_TEXT_WRITER_SCROLL_EN.
//   state        | meaning
//   ST_IDLE      | accepting bytes, printable/BS writes issued next cycle
//   ST_CLEAR_ALL | writing spaces to every cell, then cursor (0,0)
//   ST_SCROLL    | copying cell k+NUM_COLS to cell k
//   ST_CLEAR_ROW | blanking the last row, then cursor (NUM_ROWS-1,0)
module vga_text_writer
    import vga_console_pkg::*;
#(
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int NUM_COLS = NUM_COLS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] rd_addr,
    input  logic [6:0] rd_data,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [6:0] wr_data,
    output logic [1:0] cur_row,
    output logic [3:0] cur_col,
    output logic       busy
);

    localparam logic [5:0] LAST_CELL = 6'(NUM_ROWS * NUM_COLS - 1);
    localparam logic [1:0] LAST_ROW  = 2'(NUM_ROWS - 1);
    localparam logic [3:0] LAST_COL  = 4'(NUM_COLS - 1);
`ifdef VGA_TEXT_WRITER_SCROLL_EN
    localparam logic [5:0] LAST_COPY  = 6'((NUM_ROWS - 1) * NUM_COLS - 1);
    localparam logic [5:0] ROW_BASE   = 6'((NUM_ROWS - 1) * NUM_COLS);
    localparam logic [5:0] COL_STRIDE = 6'(NUM_COLS);
    localparam logic [5:0] ROW_END    = 6'(NUM_COLS - 1);
`endif

    state_e     state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic [5:0] cnt_q, cnt_d;
    logic       wr_en_q, wr_en_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    logic [6:0] wr_data_q, wr_data_d;

    logic       accept;
    logic       advance;
    logic [5:0] here_idx;
    logic [5:0] back_idx;

    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);
    assign here_idx = cell_index(row_q, col_q, NUM_COLS);
    assign back_idx = cell_index(row_q, col_q - 4'd1, NUM_COLS);

`ifdef VGA_TEXT_WRITER_SCROLL_EN
    // Read runs one row ahead of the write, so a copy never reads a cell already overwritten.
    assign rd_addr = (state_q == ST_SCROLL) ? (cnt_q + COL_STRIDE) : 6'd0;
`else
    logic unused_rd;
    assign unused_rd = ^rd_data;
    assign rd_addr   = 6'd0;
`endif

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cur_row = row_q;
    assign cur_col = col_q;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(in_data)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = here_idx;
                        wr_data_d = in_data[6:0];
                        if (col_q == LAST_COL) begin
                            col_d   = 4'd0;
                            advance = 1'b1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end else if (in_data == CH_LF) begin
                        col_d   = 4'd0;
                        advance = 1'b1;
                    end else if (in_data == CH_CR) begin
                        col_d = 4'd0;
                    end else if (in_data == CH_BS) begin
                        if (col_q != 4'd0) begin
                            col_d     = col_q - 4'd1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = back_idx;
                            wr_data_d = CH_SPACE;
                        end
                    end else if (in_data == CH_FF) begin
                        state_d = ST_CLEAR_ALL;
                        cnt_d   = 6'd0;
                    end
                end
                if (advance) begin
                    if (row_q != LAST_ROW) begin
                        row_d = row_q + 2'd1;
                    end else begin
`ifdef VGA_TEXT_WRITER_SCROLL_EN
                        state_d = ST_SCROLL;
                        cnt_d   = 6'd0;
`else
                        row_d = 2'd0;
                        col_d = 4'd0;
`endif
                    end
                end
            end

            ST_CLEAR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = CH_SPACE;
                if (cnt_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                    row_d   = 2'd0;
                    col_d   = 4'd0;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

`ifdef VGA_TEXT_WRITER_SCROLL_EN
            ST_SCROLL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = rd_data;
                if (cnt_q == LAST_COPY) begin
                    state_d = ST_CLEAR_ROW;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            ST_CLEAR_ROW: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ROW_BASE + cnt_q;
                wr_data_d = CH_SPACE;
                if (cnt_q == ROW_END) begin
                    state_d = ST_IDLE;
                    row_d   = LAST_ROW;
                    col_d   = 4'd0;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
`endif

            default: begin
                state_d = ST_CLEAR_ALL;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR_ALL;
            row_q     <= 2'd0;
            col_q     <= 4'd0;
            cnt_q     <= 6'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 6'd0;
            wr_data_q <= 7'd0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Bench for vga_text_writer: cycle-scheduled behavioural model plus directed literal checks.
// Follows VGA_TEXT_WRITER_SCROLL_EN the same way the design does.
module tb_vga_text_writer;
    import vga_console_pkg::*;

    localparam int R = NUM_ROWS_DEF;
    localparam int C = NUM_COLS_DEF;
    localparam int CELLS = R * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] rd_addr;
    logic [6:0] rd_data;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [6:0] wr_data;
    logic [1:0] cur_row;
    logic [3:0] cur_col;
    logic       busy;

    vga_text_writer dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Console peripheral buffer with asynchronous read.
    logic [6:0] mem [0:63] = '{default: 7'h00};
    always @(posedge clk) if (wr_en === 1'b1) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: cursor, screen image and a per-cycle schedule of expected writes.
    int         cyc = 0;
    bit         chk_en = 1'b0;
    int         idle_from = 0;
    int         scroll_s = -100;
    int         mrow = 0;
    int         mcol = 0;
    int         n_acc = 0;
    logic [6:0] scr [0:CELLS-1];
    logic [12:0] exp_wr [int];
    int         stale[$];

    int         wcount = 0;
    logic [5:0] last_addr = 6'd0;
    logic [6:0] last_data = 7'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic start_clear(input int c);
        for (int i = 0; i < CELLS; i++) begin
            exp_wr[c + 2 + i] = {6'(i), CH_SPACE};
            scr[i] = CH_SPACE;
        end
        idle_from = c + CELLS + 1;
        mrow = 0;
        mcol = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input int c);
        bit adv = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_wr[c + 1] = {6'(mrow * C + mcol), b[6:0]};
            scr[mrow * C + mcol] = b[6:0];
            if (mcol == C - 1) begin
                mcol = 0;
                adv = 1'b1;
            end else begin
                mcol++;
            end
        end else if (b == CH_LF) begin
            mcol = 0;
            adv = 1'b1;
        end else if (b == CH_CR) begin
            mcol = 0;
        end else if (b == CH_BS) begin
            if (mcol > 0) begin
                mcol--;
                exp_wr[c + 1] = {6'(mrow * C + mcol), CH_SPACE};
                scr[mrow * C + mcol] = CH_SPACE;
            end
        end else if (b == CH_FF) begin
            start_clear(c);
        end
        if (adv) begin
            if (mrow < R - 1) begin
                mrow++;
            end else begin
`ifdef VGA_TEXT_WRITER_SCROLL_EN
                for (int k = 0; k < (R - 1) * C; k++) begin
                    exp_wr[c + 2 + k] = {6'(k), scr[k + C]};
                    scr[k] = scr[k + C];
                end
                for (int j = 0; j < C; j++) begin
                    exp_wr[c + 2 + (R - 1) * C + j] = {6'((R - 1) * C + j), CH_SPACE};
                    scr[(R - 1) * C + j] = CH_SPACE;
                end
                idle_from = c + CELLS + 1;
                scroll_s = c + 1;
`else
                mrow = 0;
                mcol = 0;
`endif
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            stale.delete();
            foreach (exp_wr[k]) if (k > cyc) stale.push_back(k);
            foreach (stale[i]) exp_wr.delete(stale[i]);
            start_clear(cyc);
            scroll_s = -100;
            chk_en = 1'b1;
        end else if (cyc >= idle_from && in_valid) begin
            model_byte(in_data, cyc);
            n_acc++;
        end
        cyc++;
    end

    bit          ew;
    logic [12:0] ev;
    int          era;
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wcount++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (chk_en) begin
            ew = exp_wr.exists(cyc);
            chk("wr_en", 32'(wr_en), 32'(ew));
            if (ew && wr_en === 1'b1) begin
                ev = exp_wr[cyc];
                chk("wr_addr", 32'(wr_addr), 32'(ev[12:7]));
                chk("wr_data", 32'(wr_data), 32'(ev[6:0]));
            end
            chk("in_ready", 32'(in_ready), 32'(!rst && cyc >= idle_from));
            chk("busy", 32'(busy), 32'(cyc < idle_from));
            era = (cyc >= scroll_s && cyc < scroll_s + (R - 1) * C) ? (cyc - scroll_s + C) : 0;
            chk("rd_addr", 32'(rd_addr), era);
            if (!rst && cyc >= idle_from) begin
                chk("cur_row", 32'(cur_row), mrow);
                chk("cur_col", 32'(cur_col), mcol);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int a0 = n_acc;
        int n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (n_acc == a0 && n < 200) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("accept", 32'(n_acc != a0), 32'd1);
    endtask

    function automatic logic [7:0] rnd_byte();
        int p = $urandom_range(0, 99);
        if (p < 60) return 8'($urandom_range(32, 126));
        if (p < 72) return CH_LF;
        if (p < 77) return CH_CR;
        if (p < 87) return CH_BS;
        if (p < 89) return CH_FF;
        return p[0] ? 8'h7F : 8'($urandom_range(128, 255));
    endfunction

    int w;
    int n;
    int lowcnt;
    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (29) tick();
        chk("busy_before_clear_done", 32'(busy), 32'd1);
        tick();
        chk("busy_after_clear_done", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("reset_write_count", wcount, 32'd30);
        chk("reset_last_addr", 32'(last_addr), 32'd29);
        chk("reset_last_data", 32'(last_data), 32'h20);
        chk("reset_cursor_row", 32'(cur_row), 32'd0);
        chk("reset_cursor_col", 32'(cur_col), 32'd0);

        send("H");
        send("I");
        repeat (3) tick();
        chk("hi_last_addr", 32'(last_addr), 32'd1);
        chk("hi_last_data", 32'(last_data), 32'h49);
        chk("hi_cursor_col", 32'(cur_col), 32'd2);

        send(CH_FF);
        repeat (35) tick();
        for (int i = 0; i < 10; i++) send("A");
        repeat (3) tick();
        chk("row_fill_last_addr", 32'(last_addr), 32'd9);
        chk("row_fill_cursor_row", 32'(cur_row), 32'd1);
        chk("row_fill_cursor_col", 32'(cur_col), 32'd0);

        w = wcount;
        send(CH_BS);
        repeat (3) tick();
        chk("bs_col0_no_write", wcount - w, 32'd0);
        send("B");
        send(CH_BS);
        repeat (3) tick();
        chk("bs_last_addr", 32'(last_addr), 32'd10);
        chk("bs_last_data", 32'(last_data), 32'h20);
        chk("bs_cursor_col", 32'(cur_col), 32'd0);

        send(CH_LF);
        send("Z");
        send(CH_CR);
        repeat (2) tick();
        chk("cr_cursor_row", 32'(cur_row), 32'd2);
        chk("cr_cursor_col", 32'(cur_col), 32'd0);

        w = wcount;
        lowcnt = 0;
        send(CH_LF);
        for (int i = 0; i < 31; i++) begin
            if (!in_ready) lowcnt++;
            tick();
        end
        repeat (5) tick();
`ifdef VGA_TEXT_WRITER_SCROLL_EN
        chk("scroll_write_count", wcount - w, 32'd30);
        chk("scroll_ready_low", lowcnt, 32'd30);
        chk("scroll_moved_char", 32'(mem[10]), 32'h5A);
        chk("scroll_cursor_row", 32'(cur_row), 32'd2);

        send(CH_LF);
        n = 0;
        while (rd_addr != 6'd17 && n < 50) begin
            tick();
            n++;
        end
        chk("scroll_k7_reached", 32'(rd_addr), 32'd17);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w = wcount;
        n = 0;
        while (wcount == w && n < 50) begin
            tick();
            n++;
        end
        chk("reset_restart_addr", 32'(last_addr), 32'd0);
        chk("reset_restart_data", 32'(last_data), 32'h20);
        repeat (40) tick();
`else
        chk("wrap_no_writes", wcount - w, 32'd0);
        chk("wrap_cursor_row", 32'(cur_row), 32'd0);
        chk("wrap_cursor_col", 32'(cur_col), 32'd0);
`endif

        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = rnd_byte();
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
